// File: rtl/ysyx_22041412_mem_responder.sv
// rtl/ysyx_22041412_mem_responder.sv - burst responder between the cache refill/write-back channel and a 1-cycle SRAM
module ysyx_22041412_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int SRAM_AW     = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic [7:0]            r_len_i,
  output logic                  r_ready_o,
  output logic                  r_last_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  w_valid_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [7:0]            w_len_i,
  input  logic [2:0]            w_size_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  w_ready_o,
  output logic                  w_last_o,
  output logic                  busy_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [SRAM_AW-1:0]    sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [7:0]            sram_wmask_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RWAIT  = 3'd1,
    RBURST = 3'd2,
    WWAIT  = 3'd3,
    WBEAT  = 3'd4,
    WGAP   = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [3:0]            WAIT_LD    = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(7));

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;   // byte address of the beat being issued
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [2:0]            size_q;
  logic [2:0]            off_q;      // original byte offset, only meaningful for single-beat writes
  logic [3:0]            wait_cnt;

  // Write-beat setup is shared by the IDLE (no wait), WWAIT and WGAP paths;
  // in IDLE the request has not been latched yet, so take it straight from the inputs.
  logic [7:0]            wr_src_len;
  logic [7:0]            wr_src_cnt;
  logic [2:0]            wr_src_size;
  logic [2:0]            wr_src_off;
  logic [SRAM_AW-1:0]    wr_idx_nxt;
  logic [7:0]            wr_mask_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic                  wr_last_nxt;

  // Byte mask for a write beat: full for bursts, size-wide and offset-shifted for singles.
  // Shifting an 8-bit mask naturally drops lanes past byte 7.
  function automatic logic [7:0] lane_mask(input logic [7:0] len, input logic [2:0] size,
                                           input logic [2:0] off);
    logic [7:0] m;
    case (size)
      3'b000:  m = 8'h01;
      3'b001:  m = 8'h03;
      3'b010:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    m = m << off;
    if (len != 8'd0) m = 8'hFF;
    return m;
  endfunction

  // Single-beat writes carry their data in the low lanes; move it to the addressed lanes.
  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [7:0] len,
                                                      input logic [2:0] off);
    return (len == 8'd0) ? (d << {off, 3'b000}) : d;
  endfunction

  assign nxt_addr = cur_addr + BEAT_BYTES;
  assign busy_o   = (state != IDLE);
  // Read data comes straight out of the SRAM's output register; zero it outside read beats.
  assign r_data_o = r_ready_o ? sram_rdata_i : '0;

  // Select the source of the next write beat (live request in IDLE, latched request otherwise)
  always_comb begin
    wr_src_len  = len_q;
    wr_src_cnt  = beat_cnt;
    wr_src_size = size_q;
    wr_src_off  = off_q;
    wr_idx_nxt  = cur_addr[SRAM_AW+2:3];
    if (state == IDLE) begin
      wr_src_len  = w_len_i;
      wr_src_cnt  = 8'd0;
      wr_src_size = w_size_i;
      wr_src_off  = w_addr_i[2:0];
      wr_idx_nxt  = w_addr_i[SRAM_AW+2:3];
    end
    wr_mask_nxt = lane_mask(wr_src_len, wr_src_size, wr_src_off);
    wr_data_nxt = lane_data(w_data_i, wr_src_len, wr_src_off);
    wr_last_nxt = (wr_src_cnt == wr_src_len);
  end

  // Request FSM; every output is registered and describes the coming cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur_addr     <= '0;
      len_q        <= '0;
      size_q       <= '0;
      off_q        <= '0;
      beat_cnt     <= '0;
      wait_cnt     <= '0;
      r_ready_o    <= 1'b0;
      r_last_o     <= 1'b0;
      w_ready_o    <= 1'b0;
      w_last_o     <= 1'b0;
      sram_en_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      sram_wmask_o <= '0;
    end else begin
      // Handshakes and SRAM strobes are single-cycle unless a state re-arms them.
      r_ready_o    <= 1'b0;
      r_last_o     <= 1'b0;
      w_ready_o    <= 1'b0;
      w_last_o     <= 1'b0;
      sram_en_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      sram_wmask_o <= '0;

      case (state)
        IDLE: begin
          beat_cnt <= 8'd0;
          wait_cnt <= WAIT_LD;
          if (w_valid_i) begin
            // write-back goes first so a refill never reads stale lines
            cur_addr <= w_addr_i & ALIGN_MASK;
            len_q    <= w_len_i;
            size_q   <= w_size_i;
            off_q    <= w_addr_i[2:0];
            if (WAIT_CYCLES != 0) begin
              state <= WWAIT;
            end else begin
              state        <= WBEAT;
              w_ready_o    <= 1'b1;
              w_last_o     <= wr_last_nxt;
              sram_en_o    <= 1'b1;
              sram_we_o    <= 1'b1;
              sram_addr_o  <= wr_idx_nxt;
              sram_wdata_o <= wr_data_nxt;
              sram_wmask_o <= wr_mask_nxt;
            end
          end else if (r_valid_i) begin
            cur_addr <= r_addr_i & ALIGN_MASK;
            len_q    <= r_len_i;
            size_q   <= 3'b011;
            off_q    <= r_addr_i[2:0];
            if (WAIT_CYCLES != 0) begin
              state <= RWAIT;
            end else begin
              state       <= RBURST;
              sram_en_o   <= 1'b1;
              sram_addr_o <= r_addr_i[SRAM_AW+2:3];
            end
          end
        end

        RWAIT: begin
          if (wait_cnt <= 4'd1) begin
            state       <= RBURST;
            sram_en_o   <= 1'b1;
            sram_addr_o <= cur_addr[SRAM_AW+2:3];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        RBURST: begin
          // The read issued this cycle returns next cycle as a ready beat.
          r_ready_o <= 1'b1;
          r_last_o  <= (beat_cnt == len_q);
          if (beat_cnt == len_q) begin
            state <= DONE;
          end else begin
            beat_cnt    <= beat_cnt + 8'd1;
            cur_addr    <= nxt_addr;
            sram_en_o   <= 1'b1;
            sram_addr_o <= nxt_addr[SRAM_AW+2:3];
          end
        end

        WWAIT: begin
          if (wait_cnt <= 4'd1) begin
            state        <= WBEAT;
            w_ready_o    <= 1'b1;
            w_last_o     <= wr_last_nxt;
            sram_en_o    <= 1'b1;
            sram_we_o    <= 1'b1;
            sram_addr_o  <= wr_idx_nxt;
            sram_wdata_o <= wr_data_nxt;
            sram_wmask_o <= wr_mask_nxt;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        WBEAT: begin
          if (beat_cnt == len_q) begin
            state <= DONE;
          end else begin
            state    <= WGAP;
            beat_cnt <= beat_cnt + 8'd1;
            cur_addr <= nxt_addr;
          end
        end

        WGAP: begin
          // requester has presented the next beat's data by now
          state        <= WBEAT;
          w_ready_o    <= 1'b1;
          w_last_o     <= wr_last_nxt;
          sram_en_o    <= 1'b1;
          sram_we_o    <= 1'b1;
          sram_addr_o  <= wr_idx_nxt;
          sram_wdata_o <= wr_data_nxt;
          sram_wmask_o <= wr_mask_nxt;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_mem_responder.sv
// tb/tb_ysyx_22041412_mem_responder.sv - scoreboard bench for ysyx_22041412_mem_responder
module tb_ysyx_22041412_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_valid, w_valid;
  logic [31:0] r_addr, w_addr;
  logic [7:0]  r_len, w_len;
  logic [2:0]  w_size;
  logic [63:0] w_data;
  logic        r_ready_o, r_last_o, w_ready_o, w_last_o, busy_o;
  logic [63:0] r_data_o;
  logic        sram_en_o, sram_we_o;
  logic [15:0] sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [7:0]  sram_wmask_o;
  logic [63:0] sram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          wr;
    bit          last;
    logic [15:0] idx;
    logic [63:0] data;
    logic [7:0]  mask;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [logic [15:0]];
  logic [63:0] sram [0:65535];
  logic [63:0] wbeats [0:15];

  ysyx_22041412_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .SRAM_AW(16), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .r_valid_i(r_valid), .r_addr_i(r_addr), .r_len_i(r_len),
    .r_ready_o(r_ready_o), .r_last_o(r_last_o), .r_data_o(r_data_o),
    .w_valid_i(w_valid), .w_addr_i(w_addr), .w_len_i(w_len), .w_size_i(w_size),
    .w_data_i(w_data), .w_ready_o(w_ready_o), .w_last_o(w_last_o),
    .busy_o(busy_o),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_wmask_o(sram_wmask_o), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input logic [15:0] i);
    return {16'hC0DE, i, ~i, i ^ 16'h5A5A};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [15:0] i);
    return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
  endfunction

  // SRAM model: synchronous, one cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (sram_en_o) begin
      if (sram_we_o) sram[sram_addr_o] <= merge(sram[sram_addr_o], sram_wdata_o, sram_wmask_o);
      else sram_rdata <= sram[sram_addr_o];
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic preload(input logic [15:0] i, input logic [63:0] v);
    sram[i] = v;
    ref_mem[i] = v;
  endtask

  // Expected write beats: beat i lands at base+8i, first ready at T+W+1, one gap between beats
  task automatic model_write(input logic [31:0] a, input int len, input logic [2:0] sz, input int t);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] ba;
      exp_t e;
      int off;
      int nbytes;
      ba = (a & 32'hFFFF_FFF8) + 32'(8 * i);
      e.wr = 1'b1;
      e.last = (i == len);
      e.idx = ba[18:3];
      if (len == 0) begin
        off = int'(a[2:0]);
        nbytes = 1 << sz;
        e.mask = 8'h00;
        for (int b = 0; b < 8; b++) if (b >= off && b < off + nbytes) e.mask[b] = 1'b1;
        e.data = wbeats[i] << (8 * off);
      end else begin
        e.mask = 8'hFF;
        e.data = wbeats[i];
      end
      e.cyc = t + W + 1 + 2 * i;
      ref_mem[e.idx] = merge(ref_rd(e.idx), e.data, e.mask);
      sb.push_back(e);
    end
  endtask

  // Expected read beats: back-to-back from T+W+2
  task automatic model_read(input logic [31:0] a, input int len, input int t);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] ba;
      exp_t e;
      ba = (a & 32'hFFFF_FFF8) + 32'(8 * i);
      e.wr = 1'b0;
      e.last = (i == len);
      e.idx = ba[18:3];
      e.data = ref_rd(e.idx);
      e.mask = 8'h00;
      e.cyc = t + W + 2 + i;
      sb.push_back(e);
    end
  endtask

  task automatic drv_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
    int n;
    int beat;
    n = 0;
    beat = 0;
    w_addr = a; w_len = len; w_size = sz; w_data = wbeats[0]; w_valid = 1'b1;
    while (beat <= int'(len) && n < 600) begin
      @(negedge clk);
      n++;
      if (w_ready_o) begin
        beat++;
        @(posedge clk);
        #1;
        if (beat <= int'(len)) w_data = wbeats[beat];
        else w_valid = 1'b0;
      end
    end
    w_valid = 1'b0;
    check64("write_completed_in_time", 64'(beat), 64'(int'(len) + 1));
  endtask

  task automatic drv_read(input logic [31:0] a, input logic [7:0] len);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    r_addr = a; r_len = len; r_valid = 1'b1;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
      if (r_ready_o && r_last_o) done = 1'b1;
    end
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    check64("read_completed_in_time", 64'(done), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check64("idle_reached", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int t;
    int lw;
    rst = 1'b1;
    r_valid = 1'b0; r_addr = '0; r_len = '0;
    w_valid = 1'b0; w_addr = '0; w_len = '0; w_size = '0; w_data = '0;
    sram_rdata = '0;
    for (int i = 0; i < 65536; i++) sram[i] = init_word(16'(i));
    repeat (3) @(posedge clk);
    #1;
    check64("rst_r_ready", 64'(r_ready_o), 64'd0);
    check64("rst_w_ready", 64'(w_ready_o), 64'd0);
    check64("rst_sram_en", 64'({sram_en_o, sram_we_o}), 64'd0);
    check64("rst_busy", 64'(busy_o), 64'd0);
    check64("rst_r_data", r_data_o, 64'd0);
    check64("rst_sram_addr", 64'(sram_addr_o), 64'd0);
    rst = 1'b0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst) begin
            checks++;
            if ((r_ready_o && w_ready_o) || (r_last_o && !r_ready_o) || (w_last_o && !w_ready_o)) begin
              errors++;
              $display("FAIL handshake_rules: r_ready=%b r_last=%b w_ready=%b w_last=%b, expected exclusive readies and last only with ready (cyc %0d)",
                       r_ready_o, r_last_o, w_ready_o, w_last_o, cyc);
            end
            if (r_ready_o || w_ready_o) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got a beat at cyc %0d, expected none", cyc);
              end else begin
                e = sb.pop_front();
                check64("beat_is_write", 64'(w_ready_o), 64'(e.wr));
                check64("beat_cycle", 64'(cyc), 64'(e.cyc));
                if (e.wr) begin
                  check64("w_last", 64'(w_last_o), 64'(e.last));
                  check64("sram_en_we", 64'({sram_en_o, sram_we_o}), 64'd3);
                  check64("sram_waddr", 64'(sram_addr_o), 64'(e.idx));
                  check64("sram_wdata", sram_wdata_o, e.data);
                  check64("sram_wmask", 64'(sram_wmask_o), 64'(e.mask));
                end else begin
                  check64("r_last", 64'(r_last_o), 64'(e.last));
                  check64("r_data", r_data_o, e.data);
                end
              end
            end
          end
        end
      end
    join_none

    // Refill of four words
    for (int i = 0; i < 4; i++) preload(16'(32 + i), 64'hA0A0_0000_0000_0000 + 64'(i * 64'h0101_0101_0101));
    wait_idle();
    t = cyc; model_read(32'h100, 3, t); drv_read(32'h100, 8'd3);

    // Single word store into the upper half of a beat, then read it back
    wait_idle();
    wbeats[0] = 64'h1122_3344_5566_7788;
    t = cyc; model_write(32'h104, 0, 3'b010, t); drv_write(32'h104, 8'd0, 3'b010);
    wait_idle();
    t = cyc; model_read(32'h100, 0, t); drv_read(32'h100, 8'd0);

    // Write and read requested together: write first, read after DONE
    wait_idle();
    wbeats[0] = {$urandom, $urandom};
    wbeats[1] = {$urandom, $urandom};
    t = cyc;
    model_write(32'h300, 1, 3'b011, t);
    lw = t + W + 1 + 2;
    model_read(32'h300, 7, lw + 2);
    fork
      drv_write(32'h300, 8'd1, 3'b011);
      drv_read(32'h300, 8'd7);
    join

    // Address wrap at the top of the byte space
    preload(16'hFFFF, 64'hFEED_FACE_0000_FFFF);
    preload(16'h0000, 64'hBEEF_0000_0000_0000);
    wait_idle();
    t = cyc; model_read(32'hFFFF_FFF8, 1, t); drv_read(32'hFFFF_FFF8, 8'd1);

    // Asynchronous reset in the middle of a read burst
    wait_idle();
    begin
      int n;
      int beats;
      t = cyc;
      model_read(32'h400, 7, t);
      r_addr = 32'h400; r_len = 8'd7; r_valid = 1'b1;
      n = 0;
      beats = 0;
      while (beats < 2 && n < 100) begin
        @(negedge clk);
        n++;
        if (r_ready_o) beats++;
      end
      check64("beats_before_reset", 64'(beats), 64'd2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check64("async_rst_r_ready", 64'(r_ready_o), 64'd0);
      check64("async_rst_sram_en", 64'(sram_en_o), 64'd0);
      check64("async_rst_busy", 64'(busy_o), 64'd0);
      check64("async_rst_r_data", r_data_o, 64'd0);
      sb.delete();
      r_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    wait_idle();
    t = cyc; model_read(32'h400, 3, t); drv_read(32'h400, 8'd3);

    // Doubleword store then load of the same address
    wait_idle();
    wbeats[0] = 64'h0123_4567_89AB_CDEF;
    t = cyc; model_write(32'h8, 0, 3'b011, t); drv_write(32'h8, 8'd0, 3'b011);
    wait_idle();
    t = cyc; model_read(32'h8, 0, t); drv_read(32'h8, 8'd0);

    // Misaligned halfword crossing the beat end
    wait_idle();
    wbeats[0] = 64'h0000_0000_0000_BBAA;
    t = cyc; model_write(32'h107, 0, 3'b001, t); drv_write(32'h107, 8'd0, 3'b001);

    // Random mix of reads and writes
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int len;
      logic [2:0] sz;
      bit wr;
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      len = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 9));
      sz = 3'($urandom_range(0, 3));
      wait_idle();
      t = cyc;
      if (wr) begin
        for (int i = 0; i <= len; i++) wbeats[i] = {$urandom, $urandom};
        model_write(a, len, sz, t);
        drv_write(a, 8'(len), sz);
      end else begin
        model_read(a, len, t);
        drv_read(a, 8'(len));
      end
    end

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check64("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
